// File: rtl/mdio_mgmt_ctrl.sv
// mdio_mgmt_ctrl: Clause-22 MDIO master arbitrating user commands against a periodic BMSR link poller
module mdio_mgmt_ctrl #(
  parameter int         CLK_DIV       = 25,
  parameter logic [4:0] PHY_ADDR      = 5'd1,
  parameter bit         POLL_EN       = 1'b1,
  parameter int         POLL_INTERVAL = 1000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        link_up,
  output logic        link_valid,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int TW = $clog2(POLL_INTERVAL);
  if (CLK_DIV < 2 || POLL_INTERVAL < 2) begin : g_bad_param
    $error("mdio_mgmt_ctrl: CLK_DIV and POLL_INTERVAL must both be at least 2");
  end
  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, IDLE_BIT, DONE} state_t;
  state_t          state, nxt, ns;
  logic [PW-1:0]   ph;
  logic [4:0]      cnt, cnt_max;
  logic [31:0]     sh;
  logic [TW-1:0]   timer;
  logic [15:0]     rdata;
  logic            err, rd, is_poll, last_user, poll_pending;
  logic            user_go, poll_go, rise, samp, bit_end, adv, o_nx, t_nx, shift, timer_wrap, poll_done;
  assign cmd_ready  = (state == IDLE) && !(poll_pending && last_user);
  assign poll_go    = (state == IDLE) && poll_pending && (!cmd_valid || last_user);
  assign user_go    = cmd_valid && cmd_ready;
  assign rise       = ph == PW'(CLK_DIV - 1);
  assign samp       = ph == PW'(CLK_DIV);
  assign bit_end    = ph == PW'(2 * CLK_DIV - 1);
  assign timer_wrap = timer == TW'(POLL_INTERVAL - 1);
  // Bit-boundary bookkeeping: which field comes next and what the line carries for it
  always_comb begin
    nxt     = state == PRE ? HDR : state == HDR ? TA : state == TA ? DATA : state == DATA ? IDLE_BIT : DONE;
    cnt_max = state == PRE ? 5'd31 : state == HDR ? 5'd13 : state == TA ? 5'd1 : state == DATA ? 5'd15 : 5'd0;
    adv     = bit_end && cnt == cnt_max;
    ns      = adv ? nxt : state;
    shift   = ns == HDR || ns == TA || ns == DATA;
    o_nx    = shift ? sh[31] : 1'b1;
    t_nx    = (ns == PRE || ns == HDR) ? 1'b0 : (ns == TA || ns == DATA) ? rd : 1'b1;
  end
  assign poll_done = state == IDLE_BIT && bit_end && is_poll;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      ph           <= '0;
      cnt          <= '0;
      sh           <= '0;
      rd           <= 1'b0;
      is_poll      <= 1'b0;
      last_user    <= 1'b0;
      poll_pending <= 1'b0;
      timer        <= '0;
      rdata        <= '0;
      err          <= 1'b0;
      mdc          <= 1'b0;
      mdio_o       <= 1'b1;
      mdio_t       <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
      link_up      <= 1'b0;
      link_valid   <= 1'b0;
    end else begin
      rsp_valid    <= 1'b0;
      timer        <= (POLL_EN && !timer_wrap) ? timer + TW'(1) : '0;
      poll_pending <= (POLL_EN && timer_wrap) || (poll_pending && !poll_done);
      if (state == IDLE) begin
        if (user_go || poll_go) begin
          state   <= PRE;
          ph      <= '0;
          cnt     <= '0;
          busy    <= 1'b1;
          mdc     <= 1'b0;
          mdio_o  <= 1'b1;
          mdio_t  <= 1'b0;
          rd      <= poll_go || !cmd_write;
          is_poll <= poll_go;
          rdata   <= '0;
          err     <= 1'b0;
          sh      <= poll_go ? {4'b0110, PHY_ADDR, 5'd1, 2'b11, 16'h0000}
                             : {2'b01, cmd_write ? 2'b01 : 2'b10, cmd_phy, cmd_reg, 2'b10, cmd_wdata};
        end
      end else if (state == DONE) begin
        state <= IDLE;
      end else begin
        ph  <= bit_end ? '0 : ph + PW'(1);
        mdc <= bit_end ? 1'b0 : rise ? 1'b1 : mdc;
        if (samp && rd && state == TA && cnt == 5'd1) err <= mdio_i;
        if (samp && rd && state == DATA) rdata <= {rdata[14:0], mdio_i};
        if (bit_end) begin
          state  <= ns;
          cnt    <= adv ? 5'd0 : cnt + 5'd1;
          mdio_o <= o_nx;
          mdio_t <= t_nx;
          if (shift) sh <= {sh[30:0], 1'b0};
          if (ns == DONE) begin
            busy      <= 1'b0;
            last_user <= !is_poll;
            if (is_poll) begin
              link_up    <= err ? 1'b0 : rdata[2];
              link_valid <= 1'b1;
            end else begin
              rsp_valid <= 1'b1;
              rsp_rdata <= rdata;
              rsp_err   <= err;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mdio_mgmt_ctrl.sv
// tb_mdio_mgmt_ctrl: scoreboard bench for mdio_mgmt_ctrl against a behavioural Clause-22 PHY
module tb_mdio_mgmt_ctrl;
  localparam int CD = 4;
  logic clk = 1'b0;
  logic resetn, cmd_valid, cmd_write, cmd_ready, rsp_valid, rsp_err, busy, link_up, link_valid;
  logic mdc, mdio_o, mdio_t, mdio_i;
  logic [4:0]  cmd_phy, cmd_reg;
  logic [15:0] cmd_wdata, rsp_rdata;
  always #5 clk = ~clk;

  mdio_mgmt_ctrl #(.CLK_DIV(CD), .PHY_ADDR(5'd1), .POLL_EN(1'b1), .POLL_INTERVAL(200)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_phy(cmd_phy), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .link_up(link_up), .link_valid(link_valid),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i)
  );

  // PHY model: open-drain bus with pull-up, answers reads addressed to PHY 1
  logic        phy_oe, phy_bit, phy_en;
  logic [15:0] regs [32];
  assign mdio_i = mdio_t ? (phy_oe ? phy_bit : 1'b1) : mdio_o;

  int cyc = 0, rsp_cnt = 0, ones, hcnt, ncnt;
  logic mdc_q = 1'b0, b, in_hdr, st_wait, rd_act;
  logic [11:0] hdr;
  logic [15:0] rd_word;
  bit cap_b[$], cap_t[$];
  logic [16:0] exp_q[$];
  int total = 0, bad = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rsp_valid) rsp_cnt++;
      if (!resetn) begin
        ones = 0; in_hdr = 0; st_wait = 0; rd_act = 0; ncnt = 0; hcnt = 0;
        phy_oe <= 1'b0; phy_bit <= 1'b1;
      end else begin
        if (mdc && !mdc_q) begin
          b = mdio_t ? mdio_i : mdio_o;
          cap_b.push_back(b);
          cap_t.push_back(mdio_t);
          if (in_hdr) begin
            hdr = {hdr[10:0], b};
            hcnt++;
            if (hcnt == 12) begin
              in_hdr = 0; ones = 0;
              if (phy_en && hdr[11:10] == 2'b10 && hdr[9:5] == 5'd1) begin
                rd_act = 1; ncnt = 0; rd_word = regs[hdr[4:0]];
              end
            end
          end else if (st_wait) begin
            st_wait = 0; in_hdr = b; hcnt = 0; ones = 0;
          end else if (b) ones++;
          else begin
            st_wait = ones >= 32; ones = 0;
          end
        end
        if (!mdc && mdc_q && rd_act) begin
          ncnt++;
          if (ncnt == 1) phy_oe <= 1'b0;
          else if (ncnt == 2) begin phy_oe <= 1'b1; phy_bit <= 1'b0; end
          else if (ncnt <= 18) phy_bit <= rd_word[18 - ncnt];
          else begin phy_oe <= 1'b0; phy_bit <= 1'b1; rd_act = 0; end
        end
      end
      mdc_q = mdc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    cmd_valid = 1'b0;
    repeat (n) tick();
    resetn = 1'b1;
  endtask

  function automatic logic [64:0] grab(input int s, input bit sel_t);
    logic [64:0] v;
    for (int i = 0; i < 65; i++) v[64 - i] = sel_t ? cap_t[s + i] : cap_b[s + i];
    return v;
  endfunction

  task automatic issue(input logic w, input logic [4:0] p, input logic [4:0] r, input logic [15:0] wd,
                       output int acc, output int s);
    int n;
    n = 0;
    cmd_write = w; cmd_phy = p; cmd_reg = r; cmd_wdata = wd; cmd_valid = 1'b1;
    while (!cmd_ready && n < 3000) begin tick(); n++; end
    acc = cyc;
    s = cap_b.size();
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL accept_timeout: cmd_ready=%b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string nm, output int at);
    int n;
    logic [16:0] e;
    n = 0;
    while (!rsp_valid && n < 3000) begin tick(); n++; end
    at = cyc;
    total++;
    if (!rsp_valid || exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_rsp: rsp_valid=%b queued=%0d want a queued response", nm, rsp_valid, exp_q.size());
      exp_q.delete();
    end else begin
      e = exp_q.pop_front();
      if ({rsp_rdata, rsp_err} !== e) begin
        bad++;
        $display("FAIL %s_rsp: got %h/%b want %h/%b", nm, rsp_rdata, rsp_err, e[16:1], e[0]);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    total++;
    if ({mdc, mdio_t, mdio_o, rsp_valid, rsp_rdata, rsp_err, busy, link_up, link_valid} !== {3'b011, 1'b0, 16'h0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_outputs: got %b want %b",
               {mdc, mdio_t, mdio_o, rsp_valid, rsp_rdata, rsp_err, busy, link_up, link_valid}, {3'b011, 1'b0, 16'h0, 4'b0000});
    end
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
    resetn = 1'b1;
  endtask

  task automatic test_write();
    int acc, s, at;
    issue(1'b1, 5'd1, 5'd0, 16'h3100, acc, s);
    exp_q.push_back({16'h0000, 1'b0});
    wait_rsp("write", at);
    total++;
    if (at - acc != 521) begin bad++; $display("FAIL write_latency: got %0d want 521", at - acc); end
    total++;
    if (cap_b.size() < s + 65) begin
      bad++;
      $display("FAIL write_frame: captured %0d bits want 65", cap_b.size() - s);
    end else begin
      if (grab(s, 0) !== {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h3100, 1'b1}) begin
        bad++;
        $display("FAIL write_frame: got %h want %h", grab(s, 0), {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h3100, 1'b1});
      end
      total++;
      if (grab(s, 1) !== {64'h0, 1'b1}) begin
        bad++;
        $display("FAIL write_tristate: got %h want %h", grab(s, 1), {64'h0, 1'b1});
      end
    end
  endtask

  task automatic test_read();
    int acc, s, at;
    issue(1'b0, 5'd1, 5'd2, 16'h0000, acc, s);
    exp_q.push_back({16'h1234, 1'b0});
    wait_rsp("read", at);
    total++;
    if (at - acc != 521) begin bad++; $display("FAIL read_latency: got %0d want 521", at - acc); end
    total++;
    if (cap_t.size() < s + 65 || grab(s, 1) !== {46'h0, 19'h7FFFF}) begin
      bad++;
      $display("FAIL read_tristate: got %h want %h", cap_t.size() < s + 65 ? 65'h0 : grab(s, 1), {46'h0, 19'h7FFFF});
    end
  endtask

  task automatic test_read_nophy();
    int acc, s, at;
    phy_en = 1'b0;
    issue(1'b0, 5'd1, 5'd2, 16'h0000, acc, s);
    exp_q.push_back({16'hFFFF, 1'b1});
    wait_rsp("nophy", at);
    phy_en = 1'b1;
  endtask

  task automatic test_poll();
    int c0, n, rc;
    regs[1] = 16'h782D;
    do_reset(2);
    c0 = cyc;
    rc = rsp_cnt;
    n = 0;
    while (!busy && n < 1000) begin tick(); n++; end
    total++;
    if (cyc - c0 != 201) begin bad++; $display("FAIL poll_start: busy at cycle %0d want 201", cyc - c0); end
    total++;
    if (link_valid !== 1'b0) begin bad++; $display("FAIL poll_prevalid: got %b want 0", link_valid); end
    n = 0;
    while (busy && n < 1000) begin tick(); n++; end
    total++;
    if ({link_up, link_valid} !== 2'b11) begin bad++; $display("FAIL poll_link_up: got %b want 11", {link_up, link_valid}); end
    regs[1] = 16'h7809;
    n = 0;
    while (!busy && n < 1000) begin tick(); n++; end
    while (busy && n < 2000) begin tick(); n++; end
    total++;
    if ({link_up, link_valid} !== 2'b01) begin bad++; $display("FAIL poll_link_down: got %b want 01", {link_up, link_valid}); end
    total++;
    if (rsp_cnt != rc) begin bad++; $display("FAIL poll_no_rsp: got %0d pulses want 0", rsp_cnt - rc); end
    total++;
    if ({rsp_rdata, rsp_err} !== 17'h0) begin bad++; $display("FAIL poll_rsp_hold: got %h/%b want 0000/0", rsp_rdata, rsp_err); end
  endtask

  task automatic test_contention();
    string seq;
    int n, ng, last_rsp;
    logic busy_q, hs_q, hs;
    logic [16:0] e;
    seq = ""; n = 0; ng = 0; last_rsp = -1; busy_q = 1'b0; hs_q = 1'b0;
    do_reset(2);
    cmd_write = 1'b1; cmd_phy = 5'd1; cmd_reg = 5'd4; cmd_wdata = 16'hA5A5; cmd_valid = 1'b1;
    while (n < 4000 && (ng < 5 || exp_q.size() > 0)) begin
      hs = cmd_valid && cmd_ready;
      if (hs) begin
        seq = {seq, "U"}; ng++;
        exp_q.push_back({16'h0000, 1'b0});
        if (last_rsp >= 0) begin
          total++;
          if (cyc - last_rsp != 523) begin bad++; $display("FAIL contention_gap: got %0d want 523", cyc - last_rsp); end
        end
      end else if (busy && !busy_q && !hs_q) begin
        seq = {seq, "P"}; ng++;
      end
      if (rsp_valid) begin
        total++;
        last_rsp = cyc;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL contention_rsp: got unexpected response want none");
        end else begin
          e = exp_q.pop_front();
          if ({rsp_rdata, rsp_err} !== e) begin bad++; $display("FAIL contention_rsp: got %h/%b want %h/%b", rsp_rdata, rsp_err, e[16:1], e[0]); end
        end
      end
      busy_q = busy; hs_q = hs;
      tick(); n++;
      if (ng >= 5) cmd_valid = 1'b0;
    end
    total++;
    if (seq != "UPUPU") begin bad++; $display("FAIL contention_order: got %s want UPUPU", seq); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int acc, s, at, rc;
    do_reset(2);
    issue(1'b1, 5'd1, 5'd4, 16'hBEEF, acc, s);
    repeat (430) tick();
    resetn = 1'b0;
    tick();
    total++;
    if ({mdc, mdio_t, busy, rsp_valid} !== 4'b0100) begin
      bad++; $display("FAIL reset_mid: got %b want 0100", {mdc, mdio_t, busy, rsp_valid});
    end
    resetn = 1'b1;
    rc = rsp_cnt;
    repeat (700) tick();
    total++;
    if (rsp_cnt != rc) begin bad++; $display("FAIL reset_mid_no_rsp: got %0d pulses want 0", rsp_cnt - rc); end
    issue(1'b0, 5'd1, 5'd2, 16'h0000, acc, s);
    exp_q.push_back({16'h1234, 1'b0});
    wait_rsp("after_reset", at);
  endtask

  initial begin
    resetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_phy = '0; cmd_reg = '0; cmd_wdata = '0; phy_en = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = 16'(i * 257);
    regs[1] = 16'h782D;
    regs[2] = 16'h1234;
    test_reset();
    test_write();
    test_read();
    test_read_nophy();
    test_poll();
    test_contention();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdio_mgmt_ctrl.md
Name: mdio_mgmt_ctrl

Overview:
- Clause-22 MDIO management master that sequences read/write frames to the Ethernet PHY over eth_mdc/eth_mdio.
- Arbitrates between a software command port (valid/ready) and an internal periodic link-status poller that reads BMSR (reg 1).
- The poller exports link_up to the MAC/MII-to-RMII glue and to status GPIO.
- Sits in the system wrapper beside the RMII converter; the top level owns the IOBUF (mdio_o/mdio_t/mdio_i).

Parameters:
- CLK_DIV, 25: MDC half-period in clk cycles (100 MHz gives 2 MHz MDC); minimum 2, elaboration error below that.
- PHY_ADDR, 5'd1: PHY address used by the poller.
- POLL_EN, 1: 1 enables periodic BMSR polling.
- POLL_INTERVAL, 1000000: clk cycles between poll requests; minimum 2.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_phy  in  5  PHY address
- cmd_reg  in  5  register address
- cmd_wdata  in  16  write data
- rsp_valid  out  1  one-cycle pulse at end of a user transaction
- rsp_rdata  out  16  read data (0 for writes)
- rsp_err  out  1  read turnaround not pulled low by the PHY
- busy  out  1  frame in progress
- link_up  out  1  BMSR[2] from the last poll
- link_valid  out  1  high once at least one poll has completed
- mdc  out  1  management clock
- mdio_o  out  1  MDIO output value
- mdio_t  out  1  tristate control (1 = released/high-Z)
- mdio_i  in  1  MDIO input

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE; mdc=0, mdio_t=1, mdio_o=1; rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, link_up=0, link_valid=0; poll timer=0, poll_pending=0.
- Reset mid-frame aborts immediately: MDC goes low, MDIO is released, no rsp_valid is issued.
- cmd_ready = (state==IDLE) && !(poll_pending && last_user). It is combinational and may be high the first cycle after reset.
- On acceptance the block latches cmd_* and sets busy=1 from the next cycle.
- States: IDLE -> PRE (32 bits of 1) -> HDR (ST=01, OP=01 write / 10 read, PHYAD[4:0], REGAD[4:0], MSB first, 14 bits) -> TA (2 bits) -> DATA (16 bits, MSB first) -> IDLE_BIT (1 bit, mdio_t=1) -> DONE (1 cycle) -> IDLE.
- Bit timing:
  - Each bit is 2*CLK_DIV cycles: mdc low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - The divider restarts at acceptance.
  - mdio_o/mdio_t update on the first cycle of each bit, when mdc is low. The first bit is driven the cycle after acceptance.
  - mdio_i is sampled on the cycle mdc rises.
- TA: write drives 1 then 0. Read releases the line (mdio_t=1) for both bits; rsp_err = sampled mdio_i on the second TA bit.
- DATA: write drives the data bits. Read keeps mdio_t=1 and shifts the sampled bits into rdata.
- Frame length is 65 bits = 130*CLK_DIV cycles. DONE, busy=0 and rsp_valid (user transactions only) occur 130*CLK_DIV+1 cycles after the acceptance cycle.
- rsp_rdata/rsp_err hold until the next user response.
- Poller (POLL_EN=1):
  - The timer increments every clk cycle. At POLL_INTERVAL-1 it wraps to 0 and sets poll_pending.
  - A pending flag that is already set is not double-counted.
  - In IDLE the grant goes to the poll if poll_pending && (!cmd_valid || last_user); otherwise to cmd_valid. This strictly alternates under contention, so there is no starvation.
  - The poll frame is a read of PHY_ADDR reg 1. At DONE: link_up = rsp_err ? 0 : rdata[2]; link_valid=1; poll_pending cleared.
  - Polls never assert rsp_valid or change rsp_*.
- last_user is set at completion of a user command and cleared at completion of a poll.
- POLL_EN=0: the timer is held at 0 and link_up/link_valid stay 0.
- mdc stays low and mdio_t stays 1 in IDLE.

Test Plan:
- Write, CLK_DIV=4: phy=1, reg=0, wdata=0x3100 -> at mdc rising edges the bench captures 32 ones, then 0101_00001_00000_10_0011000100000000, then a released bit. rsp_valid is high exactly 521 cycles after acceptance, with rsp_rdata=0 and rsp_err=0.
- Read with a PHY model driving 0 on TA2 and data 0x1234 -> rsp_rdata=0x1234, rsp_err=0. mdio_t=1 from the start of TA through IDLE_BIT.
- Read with mdio_i pulled high (no PHY) -> rsp_rdata=0xFFFF, rsp_err=1.
- Poll, POLL_INTERVAL=200, the PHY model returns 0x782D for reg 1 -> first poll starts at cycle 200. After it, link_up=1 and link_valid=1, with no rsp_valid. The model then returns 0x7809 -> the next poll sets link_up=0.
- Contention: cmd_valid held high continuously while the poll timer fires -> grants alternate user/poll/user. cmd_ready stays low for exactly one poll frame after each user frame.
- resetn=0 for 1 cycle mid-DATA -> next cycle mdc=0, mdio_t=1, busy=0, no rsp_valid. A following command completes normally.
